conv_calc_mc: RTL and testbench
===============================

CONV_CALC_MC -- requirements
Module: conv_calc_mc

Interface
REQ-001 Parameter DATA_BITS, 8, width of unsigned pixel data and signed weights/biases.
REQ-002 Parameter FILTER_SIZE, 5, kernel edge; N = FILTER_SIZE*FILTER_SIZE taps (N >= 2).
REQ-003 Parameter CHANNELS, 4, number of output channels computed in parallel from one window.
REQ-004 Parameter OUT_BITS, 16, signed output width after saturation.
REQ-005 Port clk  input  1  rising-edge clock; single clock domain.
REQ-006 Port rst  input  1  reset; synchronous, active-high.
REQ-007 Port in_valid  input  1  window on in_data is valid.
REQ-008 Port in_ready  output  1  block accepts a window this cycle.
REQ-009 Port in_data  input  N x DATA_BITS  unsigned window pixels, index 0..N-1.
REQ-010 Port out_valid  output  1  out_data holds a result.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port out_data  output  CHANNELS x OUT_BITS  signed per-channel results.
REQ-013 Port wt_we  input  1  weight write strobe.
REQ-014 Port wt_ch  input  clog2(CHANNELS)  target channel for weight/bias write.
REQ-015 Port wt_addr  input  clog2(N)  tap index; ignored when bias_sel=1.
REQ-016 Port bias_sel  input  1  write targets channel bias instead of a weight.
REQ-017 Port wt_data  input  DATA_BITS  signed weight or bias value.

Function
REQ-018 Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-019 Each pixel zero-extended to DATA_BITS+1 signed before multiply; bias sign-extended.
REQ-020 Per channel: result = sum over k of pixel[k]*weight[ch][k] + bias[ch], full precision internally (no intermediate wrap).
REQ-021 Pipeline: 1 multiply stage, clog2(N) balanced adder-tree stages (odd operands passed through), 1 bias+saturate stage; latency L = clog2(N)+2 (7 at defaults).
REQ-022 Result saturates to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
REQ-023 Whole pipeline stalls (all stages hold) when out_valid=1 and out_ready=0; in_ready = !(out_valid && !out_ready).
REQ-024 With no stall, one window per cycle sustained; results in input order, none dropped or duplicated.
REQ-025 Each stage carries a valid bit; bubbles propagate, out_valid asserted only for real windows.
REQ-026 Weight/bias write takes effect on the clock edge with wt_we=1; a window accepted on the same edge uses old values, the next window uses new.
REQ-027 Writes permitted during stall or streaming; in-flight windows unaffected once past multiply stage.
REQ-028 out_data holds stable while out_valid=1 and out_ready=0.

Reset
REQ-029 rst=1 at a clock edge clears all stage valid bits, out_valid=0, out_data=0, in_ready=1 the following cycle.
REQ-030 Reset mid-operation discards all in-flight windows; no output for them after reset releases.
REQ-031 Weight and bias storage not affected by rst; initial contents zero (simulation) unless written.

Configuration
REQ-032 Macro CONV_CALC_MC_RELU_EN: defined -> final stage clamps negative results to 0 after saturation; undefined -> signed saturated result output unchanged; latency identical in both.

Verification
REQ-033 All weights 1, biases 0, all pixels 1, single window -> out_valid 7 cycles later, every channel = 25.
REQ-034 Channel 0 weights 127, pixels 255, bias 0 -> 809625 saturates to 32767; channel 1 weights -128 -> -32768 (0 with CONV_CALC_MC_RELU_EN).
REQ-035 Stream 10 windows with pixel[0]=i, weight[ch][0]=1, others 0; out_ready low cycles 3-5 -> 10 results 0..9 in order, out_data stable during stall, in_ready low while stalled.
REQ-036 Write channel 2 bias=-5 on same edge window A accepted, window B next -> A uses old bias (0), B result reduced by 5.
REQ-037 Assert rst with 4 windows in flight -> out_valid stays 0 until a new window is accepted and L cycles elapse; weights retained.

Source files
------------

// File: rtl/conv_calc_mc_if.sv
// Window/result handshake plus weight-write port for conv_calc_mc.
// Valid/ready on both sides; weight writes are a single-cycle strobe with no handshake.
interface conv_calc_mc_if #(
    parameter int DATA_BITS   = 8,
    parameter int FILTER_SIZE = 5,
    parameter int CHANNELS    = 4,
    parameter int OUT_BITS    = 16
);
    localparam int N  = FILTER_SIZE * FILTER_SIZE;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                                in_valid;
    logic                                in_ready;
    logic [N-1:0][DATA_BITS-1:0]         in_data;
    logic                                out_valid;
    logic                                out_ready;
    logic [CHANNELS-1:0][OUT_BITS-1:0]   out_data;
    logic                                wt_we;
    logic [CW-1:0]                       wt_ch;
    logic [AW-1:0]                       wt_addr;
    logic                                bias_sel;
    logic [DATA_BITS-1:0]                wt_data;

    modport master (
        output in_valid, in_data, out_ready, wt_we, wt_ch, wt_addr, bias_sel, wt_data,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready, wt_we, wt_ch, wt_addr, bias_sel, wt_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv_calc_mc.sv
// Multi-channel conv window MAC: multiply, balanced adder tree, bias+saturate; latency clog2(N)+2 (7 at defaults).
// Whole pipeline holds while out_valid && !out_ready; CONV_CALC_MC_RELU_EN clamps negative results to 0.
module conv_calc_mc #(
    parameter int DATA_BITS   = 8,
    parameter int FILTER_SIZE = 5,
    parameter int CHANNELS    = 4,
    parameter int OUT_BITS    = 16
) (
    input  logic          clk,
    input  logic          rst,
    conv_calc_mc_if.slave io
);
    localparam int N     = FILTER_SIZE * FILTER_SIZE;
    localparam int LVLS  = $clog2(N);
    localparam int PW    = 2 * DATA_BITS + 1;
    localparam int ACC_W = PW + LVLS + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_BITS - 1)));

    logic signed [DATA_BITS-1:0] wgt_q   [CHANNELS][N];
    logic signed [DATA_BITS-1:0] bias_q  [CHANNELS];
    logic signed [DATA_BITS-1:0] bpipe_q [LVLS+1][CHANNELS];
    logic signed [ACC_W-1:0]     tree_q  [LVLS+1][CHANNELS][N];
    logic signed [ACC_W-1:0]     tree_d  [LVLS+1][CHANNELS][N];
    logic [LVLS+1:0]                     vld_q;
    logic [CHANNELS-1:0][OUT_BITS-1:0]   out_q, out_d;
    logic signed [ACC_W-1:0]     pe, we, sum_w, sat_w;
    logic                        stall;

    assign stall        = vld_q[LVLS+1] && !io.out_ready;
    assign io.in_ready  = !stall;
    assign io.out_valid = vld_q[LVLS+1];
    assign io.out_data  = out_q;

    always_ff @(posedge clk) begin
        if (io.wt_we) begin
            if (io.bias_sel) bias_q[io.wt_ch] <= io.wt_data;
            else             wgt_q[io.wt_ch][io.wt_addr] <= io.wt_data;
        end
    end

    always_comb begin
        pe    = '0;
        we    = '0;
        sum_w = '0;
        sat_w = '0;
        out_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < N; k++) begin
                pe = ACC_W'($signed({1'b0, io.in_data[k]}));
                we = ACC_W'(wgt_q[c][k]);
                tree_d[0][c][k] = pe * we;
            end
        end
        // Level l holds ceil(N/2^l) live partial sums; slots past that stay zero.
        for (int l = 1; l <= LVLS; l++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int j = 0; j < N; j++) tree_d[l][c][j] = '0;
                for (int j = 0; j < N / 2; j++)
                    tree_d[l][c][j] = tree_q[l-1][c][2*j] + tree_q[l-1][c][2*j+1];
                if (N % 2 == 1) tree_d[l][c][N/2] = tree_q[l-1][c][N-1];
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            sum_w = tree_q[LVLS][c][0] + ACC_W'(bpipe_q[LVLS][c]);
            if (sum_w > SAT_MAX)      sat_w = SAT_MAX;
            else if (sum_w < SAT_MIN) sat_w = SAT_MIN;
            else                      sat_w = sum_w;
`ifdef CONV_CALC_MC_RELU_EN
            if (sat_w[ACC_W-1]) sat_w = '0;
`endif
            out_d[c] = sat_w[OUT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            out_q <= '0;
        end else if (!stall) begin
            vld_q <= {vld_q[LVLS:0], io.in_valid};
            out_q <= out_d;
        end
    end

    // Bias is sampled with the window so later bias writes never reach in-flight data.
    always_ff @(posedge clk) begin
        if (!stall) begin
            tree_q     <= tree_d;
            bpipe_q[0] <= bias_q;
            for (int l = 1; l <= LVLS; l++) bpipe_q[l] <= bpipe_q[l-1];
        end
    end
endmodule

// File: tb/tb_conv_calc_mc.sv
// Scoreboard bench for conv_calc_mc: directed windows with hand-computed per-channel results.
module tb_conv_calc_mc;
    localparam int DB = 8, FS = 5, CH = 4, OB = 16, N = FS * FS;
    typedef logic [N-1:0][DB-1:0]  pix_t;
    typedef logic [CH-1:0][OB-1:0] res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_calc_mc_if #(.DATA_BITS(DB), .FILTER_SIZE(FS), .CHANNELS(CH), .OUT_BITS(OB)) bus ();
    conv_calc_mc #(.DATA_BITS(DB), .FILTER_SIZE(FS), .CHANNELS(CH), .OUT_BITS(OB)) dut (
        .clk(clk), .rst(rst), .io(bus)
    );

    int   vecs = 0, miss = 0, cyc = 0, acc_cyc = 0;
    res_t exp_q[$];
    res_t mon_e, held_dat;
    logic held_vld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        vecs++;
        if (act !== req) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    function automatic int relu(int v);
`ifdef CONV_CALC_MC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic res_t r4(int c0, int c1, int c2, int c3);
        res_t r;
        r[0] = 16'(c0); r[1] = 16'(c1); r[2] = 16'(c2); r[3] = 16'(c3);
        return r;
    endfunction

    function automatic pix_t px0(int v, int other);
        pix_t p;
        for (int k = 0; k < N; k++) p[k] = 8'(other);
        p[0] = 8'(v);
        return p;
    endfunction

    // Monitor: pops the scoreboard on every output transfer and checks stall behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            if (held_vld && bus.out_valid) chk("hold_data", bus.out_data, held_dat);
            if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    miss++;
                    $display("FAIL unexpected_out: got %h, expected no output", bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.out_data !== mon_e) begin
                        miss++;
                        $display("FAIL result: got %h, expected %h", bus.out_data, mon_e);
                    end
                end
            end
            held_vld = bus.out_valid && !bus.out_ready;
            held_dat = bus.out_data;
        end else begin
            held_vld = 1'b0;
        end
    end

    task automatic wr(int ch, int a, bit bs, int d);
        #1;
        bus.in_valid = 1'b0; bus.wt_we = 1'b1; bus.wt_ch = 2'(ch);
        bus.wt_addr = 5'(a); bus.bias_sel = bs; bus.wt_data = 8'(d);
        @(posedge clk);
    endtask

    task automatic send(pix_t px, res_t e, bit push, bit wb, int wb_ch, int wb_d);
        bit r;
        int n;
        n = 0;
        #1;
        bus.in_valid = 1'b1; bus.in_data = px;
        bus.wt_we = wb; bus.wt_ch = 2'(wb_ch); bus.bias_sel = 1'b1;
        bus.wt_addr = '0; bus.wt_data = 8'(wb_d);
        do begin
            @(negedge clk);
            r = bus.in_ready;
            if (r) acc_cyc = cyc;
            @(posedge clk);
            n++;
        end while (!r && n < 100);
        if (!r) begin
            vecs++; miss++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        end else if (push) begin
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(int n);
        #1;
        bus.in_valid = 1'b0; bus.wt_we = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic lat_check(string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
        chk(nm, 64'(cyc - acc_cyc), 64'd7);
        @(posedge clk);
    endtask

    task automatic cfg_tap0();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < N; k++) wr(c, k, 1'b0, (k == 0) ? 1 : 0);
            wr(c, 0, 1'b1, 0);
        end
    endtask

    initial begin
        pix_t p;
        int   bad, n;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1; bus.wt_we = 1'b0;
        bus.wt_ch = '0; bus.wt_addr = '0; bus.bias_sel = 1'b0; bus.wt_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);

        // All-ones kernel over all-ones window.
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < N; k++) wr(c, k, 1'b0, 1);
            wr(c, 0, 1'b1, 0);
        end
        send(px0(1, 1), r4(25, 25, 25, 25), 1'b1, 1'b0, 0, 0);
        idle(1);
        lat_check("latency_basic");

        // Saturation both ways, plus an in-range channel and a negative bias-only channel.
        for (int k = 0; k < N; k++) begin
            wr(0, k, 1'b0, 127); wr(1, k, 1'b0, -128); wr(2, k, 1'b0, 1); wr(3, k, 1'b0, 0);
        end
        wr(2, 0, 1'b1, 7);
        wr(3, 0, 1'b1, -3);
        send(px0(255, 255), r4(32767, relu(-32768), 6382, relu(-3)), 1'b1, 1'b0, 0, 0);
        idle(8);

        // Tap-dependent weights over pixel[k]=k; exercises the odd pass-through tap.
        for (int k = 0; k < N; k++) begin
            wr(0, k, 1'b0, 1);
            wr(1, k, 1'b0, k - 12);
            wr(2, k, 1'b0, (k == 24) ? -1 : 0);
            wr(3, k, 1'b0, (k % 2 == 0) ? 2 : 0);
        end
        wr(0, 0, 1'b1, 0); wr(1, 0, 1'b1, 0); wr(2, 0, 1'b1, -100); wr(3, 0, 1'b1, 5);
        for (int k = 0; k < N; k++) p[k] = 8'(k);
        send(p, r4(300, 1300, relu(-124), 317), 1'b1, 1'b0, 0, 0);
        idle(8);

        // Ten-window stream with a three-cycle downstream stall.
        cfg_tap0();
        fork
            begin
                for (int i = 0; i < 10; i++) send(px0(i, 9), r4(i, i, i, i), 1'b1, 1'b0, 0, 0);
                idle(1);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!bus.out_valid && n < 100);
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle(12);

        // Bias write on the same edge as window A; window B sees the new bias.
        send(px0(50, 3), r4(50, 50, 50, 50), 1'b1, 1'b1, 2, -5);
        send(px0(60, 3), r4(60, 60, 55, 60), 1'b1, 1'b0, 0, 0);
        idle(10);

        // Reset with four windows in flight: they must vanish, weights must survive.
        for (int i = 1; i <= 4; i++) send(px0(i, 0), '0, 1'b0, 1'b0, 0, 0);
        #1;
        bus.in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        chk("post_rst_quiet", 64'(bad), 64'd0);
        @(posedge clk);
        send(px0(77, 0), r4(77, 77, 72, 77), 1'b1, 1'b0, 0, 0);
        idle(1);
        lat_check("latency_after_rst");

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            vecs++; miss++;
            $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
